// File: rtl/control_sequencer.sv
// Purpose: hardwired Moore control unit; fetch T0-T2, then decoded execute steps.
// Latency: one state per Clock; strobes are combinational from state and IR[31:27].
// Backpressure: none; the datapath captures at the edge that ends each state.
module control_sequencer #(
  parameter logic [4:0] ALU_ADD = 5'b00011,
  parameter logic [4:0] ALU_SUB = 5'b00100,
  parameter logic [4:0] ALU_AND = 5'b00101,
  parameter logic [4:0] ALU_OR  = 5'b00110
) (
  input  logic        Clock,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        CON,
  output logic        Run,
  output logic [4:0]  opcode,
  output logic        Gra, Grb, Grc, Rin, Rout, BAout,
  output logic        PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin,
  output logic        Read, Write,
  output logic        Yin, Zin, Zlowout, Zhighout, HIin, LOin, Cout, CONin
);

  typedef enum logic [3:0] {
    RST, T0, T1, T2, T3, T4, T5, T6, T7, HALT
  } state_t;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_BRX  = 5'b10010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  state_t     r_state;
  state_t     w_next;
  logic [4:0] w_op;
  logic       w_mem;   // ld/ldi/st share the base+offset address steps
  logic       w_alu;   // register-register ALU group
  logic [4:0] w_alu_sel;

  assign w_op  = IR[31:27];
  assign w_mem = (w_op == OP_LD) || (w_op == OP_LDI) || (w_op == OP_ST);
  assign w_alu = (w_op == OP_ADD) || (w_op == OP_SUB) || (w_op == OP_AND) || (w_op == OP_OR);

  // map the instruction opcode onto the ALU select for the register-register group
  always_comb begin
    w_alu_sel = ALU_ADD;
    case (w_op)
      OP_SUB:  w_alu_sel = ALU_SUB;
      OP_AND:  w_alu_sel = ALU_AND;
      OP_OR:   w_alu_sel = ALU_OR;
      default: w_alu_sel = ALU_ADD;
    endcase
  end

  // state register; clear wins over everything, abandoning any partial instruction
  always_ff @(posedge Clock) begin
    if (clear) r_state <= RST;
    else       r_state <= w_next;
  end

  // next-state and Moore strobe decode
  always_comb begin
    w_next = r_state;
    Run = 1'b1; opcode = 5'd0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
    PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0; MARin = 1'b0; MDRin = 1'b0;
    MDRout = 1'b0; IRin = 1'b0; Read = 1'b0; Write = 1'b0;
    Yin = 1'b0; Zin = 1'b0; Zlowout = 1'b0; Cout = 1'b0; CONin = 1'b0;
    // mul/div strobes are not used by this instruction set
    Zhighout = 1'b0; HIin = 1'b0; LOin = 1'b0;
    case (r_state)
      RST: begin
        Run = 1'b0;
        w_next = T0;
      end
      T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
        w_next = T1;
      end
      T1: begin
        Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
        w_next = T2;
      end
      T2: begin
        MDRout = 1'b1; IRin = 1'b1;
        w_next = T3;
      end
      T3: begin
        w_next = T4;
        if (w_mem) begin
          Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
        end else if (w_alu) begin
          Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
        end else if (w_op == OP_BRX) begin
          Gra = 1'b1; Rout = 1'b1; CONin = 1'b1;
        end else if (w_op == OP_HALT) begin
          w_next = HALT;
        end else begin
          w_next = T0;   // nop and undefined opcodes
        end
      end
      T4: begin
        w_next = T5;
        if (w_mem) begin
          Cout = 1'b1; opcode = ALU_ADD; Zin = 1'b1;
        end else if (w_alu) begin
          Grc = 1'b1; Rout = 1'b1; opcode = w_alu_sel; Zin = 1'b1;
        end else begin
          PCout = 1'b1; Yin = 1'b1;   // brx: PC into Y
        end
      end
      T5: begin
        if (w_op == OP_BRX) begin
          Cout = 1'b1; opcode = ALU_ADD; Zin = 1'b1;
          w_next = T6;
        end else if (w_op == OP_LD || w_op == OP_ST) begin
          Zlowout = 1'b1; MARin = 1'b1;
          w_next = T6;
        end else begin
          Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;   // ldi and ALU writeback
          w_next = T0;
        end
      end
      T6: begin
        if (w_op == OP_BRX) begin
          // branch condition is only consulted here
          Zlowout = CON; PCin = CON;
          w_next = T0;
        end else if (w_op == OP_ST) begin
          Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
          w_next = T7;
        end else begin
          Read = 1'b1; MDRin = 1'b1;
          w_next = T7;
        end
      end
      T7: begin
        if (w_op == OP_ST) Write = 1'b1;
        else begin
          MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end
        w_next = T0;
      end
      HALT: begin
        Run = 1'b0;
        w_next = HALT;
      end
      default: begin
        Run = 1'b0;
        w_next = RST;
      end
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Purpose: directed bench for control_sequencer with hand-computed strobe vectors.
// Latency: outputs checked 1 time unit after each rising edge.
// Backpressure: none; the bench steps the clock freely.
module tb_control_sequencer;

  logic        Clock = 1'b0;
  logic        clear;
  logic [31:0] IR;
  logic        CON;
  logic        Run;
  logic [4:0]  opcode;
  logic Gra, Grb, Grc, Rin, Rout, BAout;
  logic PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin;
  logic Read, Write;
  logic Yin, Zin, Zlowout, Zhighout, HIin, LOin, Cout, CONin;

  int checks = 0;
  int failures = 0;

  control_sequencer dut (
    .Clock(Clock), .clear(clear), .IR(IR), .CON(CON), .Run(Run), .opcode(opcode),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
    .MDRout(MDRout), .IRin(IRin), .Read(Read), .Write(Write),
    .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout), .Zhighout(Zhighout), .HIin(HIin),
    .LOin(LOin), .Cout(Cout), .CONin(CONin)
  );

  always #5 Clock = ~Clock;

  // all outputs packed into one vector so each state is a single comparison
  logic [28:0] obs_vec;
  assign obs_vec = {Run, opcode, Gra, Grb, Grc, Rin, Rout, BAout, PCout, PCin, IncPC,
                    MARin, MDRin, MDRout, IRin, Read, Write, Yin, Zin, Zlowout,
                    Zhighout, HIin, LOin, Cout, CONin};

  localparam logic [28:0] RUN   = 29'd1 << 28;
  localparam logic [28:0] GRA   = 29'd1 << 22;
  localparam logic [28:0] GRB   = 29'd1 << 21;
  localparam logic [28:0] GRC   = 29'd1 << 20;
  localparam logic [28:0] RIN   = 29'd1 << 19;
  localparam logic [28:0] ROUT  = 29'd1 << 18;
  localparam logic [28:0] BAOUT = 29'd1 << 17;
  localparam logic [28:0] PCOUT = 29'd1 << 16;
  localparam logic [28:0] PCIN  = 29'd1 << 15;
  localparam logic [28:0] INCPC = 29'd1 << 14;
  localparam logic [28:0] MARIN = 29'd1 << 13;
  localparam logic [28:0] MDRIN = 29'd1 << 12;
  localparam logic [28:0] MDROUT= 29'd1 << 11;
  localparam logic [28:0] IRIN  = 29'd1 << 10;
  localparam logic [28:0] READ  = 29'd1 << 9;
  localparam logic [28:0] WRITE = 29'd1 << 8;
  localparam logic [28:0] YIN   = 29'd1 << 7;
  localparam logic [28:0] ZIN   = 29'd1 << 6;
  localparam logic [28:0] ZLOW  = 29'd1 << 5;
  localparam logic [28:0] COUT  = 29'd1 << 1;
  localparam logic [28:0] CONIN = 29'd1 << 0;
  localparam logic [28:0] OPADD = 29'd3 << 23;
  localparam logic [28:0] OPSUB = 29'd4 << 23;

  localparam logic [31:0] IR_LD   = 32'h0080_0005;
  localparam logic [31:0] IR_LDI  = 32'h0800_0000;
  localparam logic [31:0] IR_ST   = 32'h1000_0000;
  localparam logic [31:0] IR_SUB  = 32'h2000_0000;
  localparam logic [31:0] IR_BRX  = 32'h9000_0000;
  localparam logic [31:0] IR_NOP  = 32'hD000_0000;
  localparam logic [31:0] IR_UND  = 32'h7800_0000;
  localparam logic [31:0] IR_HALT = 32'hD800_0000;

  task automatic check_eq(input string tag, input logic [28:0] obs, input logic [28:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // T0..T2 checks, then present the fetched instruction for T3 onward
  task automatic fetch(input string tag, input logic [31:0] ir);
    step(); check_eq({tag, "_T0"}, obs_vec, RUN | PCOUT | MARIN | INCPC | ZIN);
    step(); check_eq({tag, "_T1"}, obs_vec, RUN | ZLOW | PCIN | READ | MDRIN);
    step(); check_eq({tag, "_T2"}, obs_vec, RUN | MDROUT | IRIN);
    IR = ir;
  endtask

  initial begin
    clear = 1'b1; IR = 32'h0; CON = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      step(); check_eq("reset", obs_vec, 29'd0);
    end
    clear = 1'b0;

    // ld R1,5(R0): 8 cycles T0-to-T0
    fetch("ld", IR_LD);
    step(); check_eq("ld_T3", obs_vec, RUN | GRB | BAOUT | YIN);
    step(); check_eq("ld_T4", obs_vec, RUN | COUT | OPADD | ZIN);
    step(); check_eq("ld_T5", obs_vec, RUN | ZLOW | MARIN);
    step(); check_eq("ld_T6", obs_vec, RUN | READ | MDRIN);
    step(); check_eq("ld_T7", obs_vec, RUN | MDROUT | GRA | RIN);

    fetch("ldi", IR_LDI);
    step(); check_eq("ldi_T3", obs_vec, RUN | GRB | BAOUT | YIN);
    step(); check_eq("ldi_T4", obs_vec, RUN | COUT | OPADD | ZIN);
    step(); check_eq("ldi_T5", obs_vec, RUN | ZLOW | GRA | RIN);

    fetch("sub", IR_SUB);
    step(); check_eq("sub_T3", obs_vec, RUN | GRB | ROUT | YIN);
    step(); check_eq("sub_T4", obs_vec, RUN | GRC | ROUT | OPSUB | ZIN);
    step(); check_eq("sub_T5", obs_vec, RUN | ZLOW | GRA | RIN);

    fetch("st", IR_ST);
    step(); check_eq("st_T3", obs_vec, RUN | GRB | BAOUT | YIN);
    step(); check_eq("st_T4", obs_vec, RUN | COUT | OPADD | ZIN);
    step(); check_eq("st_T5", obs_vec, RUN | ZLOW | MARIN);
    step(); check_eq("st_T6", obs_vec, RUN | GRA | ROUT | MDRIN);
    step(); check_eq("st_T7", obs_vec, RUN | WRITE);

    for (int c = 0; c < 2; c++) begin
      fetch(c == 0 ? "brx0" : "brx1", IR_BRX);
      CON = (c == 1);
      step(); check_eq("brx_T3", obs_vec, RUN | GRA | ROUT | CONIN);
      step(); check_eq("brx_T4", obs_vec, RUN | PCOUT | YIN);
      step(); check_eq("brx_T5", obs_vec, RUN | COUT | OPADD | ZIN);
      step(); check_eq(c == 0 ? "brx_T6_con0" : "brx_T6_con1", obs_vec,
                       c == 0 ? RUN : (RUN | ZLOW | PCIN));
    end
    CON = 1'b0;

    fetch("nop", IR_NOP);
    step(); check_eq("nop_T3", obs_vec, RUN);
    fetch("und", IR_UND);
    step(); check_eq("und_T3", obs_vec, RUN);

    // clear during T5 of st: abandon the store, no Write ever seen
    fetch("st_clr", IR_ST);
    step(); check_eq("stc_T3", obs_vec, RUN | GRB | BAOUT | YIN);
    step(); check_eq("stc_T4", obs_vec, RUN | COUT | OPADD | ZIN);
    step(); check_eq("stc_T5", obs_vec, RUN | ZLOW | MARIN);
    clear = 1'b1;
    step(); check_eq("stc_rst", obs_vec, 29'd0);
    clear = 1'b0;

    fetch("halt", IR_HALT);
    step(); check_eq("halt_T3", obs_vec, RUN);
    for (int i = 0; i < 20; i++) begin
      step(); check_eq("halt_hold", obs_vec, 29'd0);
    end
    clear = 1'b1;
    step(); check_eq("halt_clr", obs_vec, 29'd0);
    clear = 1'b0;
    IR = IR_LD;
    step(); check_eq("restart_T0", obs_vec, RUN | PCOUT | MARIN | INCPC | ZIN);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
